// File: rtl/subservient_pkg.sv
// Shared constants for the subservient debug-port image loader.
// Holds FSM encodings, byte/word geometry and the full-word select.
package subservient_pkg;

  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam int WORD_W  = 32;
  localparam int WORD_BY = 4;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/subservient_byte_packer.sv
// Little-endian byte-to-word packer, shared by length and data phases.
// Ports: i_clk/i_rst_n, i_clr (restart), i_en (byte taken), i_byte,
//        o_word (word incl. current byte), o_last (4th byte taken now).
module subservient_byte_packer
  import subservient_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_last
);

  logic [1:0]  idx_q;
  logic [23:0] sr_q;

  // The final byte is merged combinationally so the
  // word is usable in the same cycle it completes.
  assign o_word = {i_byte, sr_q};
  assign o_last = i_en && (idx_q == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q <= 2'd0;
      sr_q  <= 24'd0;
    end else if (i_clr) begin
      idx_q <= 2'd0;
      sr_q  <= 24'd0;
    end else if (i_en) begin
      idx_q <= idx_q + 2'd1;
      sr_q  <= {i_byte, sr_q[23:8]};
    end
  end

endmodule

// File: rtl/subservient_dbg_loader.sv
// Streams a length-prefixed image into the core debug port over Wishbone.
// Ports: byte stream in, Wishbone initiator out, debug-mode and status out.
module subservient_dbg_loader
  import subservient_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          MAX_WORDS   = 128,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic        i_wb_dbg_ack,
  input  logic [31:0] i_wb_dbg_rdt,
  output logic        o_done,
  output logic        o_error
);

  localparam int NW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [2:0]        st_q, st_d;
  logic              arm_q;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     len_q, len_d;
  logic [TW-1:0]     to_q, to_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              rx, take, restart;
  logic [WORD_W-1:0] word;
  logic              last;
  logic [NW-1:0]     n_inc;

  wire unused_rdt = ^i_wb_dbg_rdt;

  assign rx      = (st_q == S_LEN) || (st_q == S_DATA);
  // arm_q keeps ready low until the first edge after reset.
  assign o_byte_ready = arm_q && rx;
  assign take    = i_byte_valid && o_byte_ready;
  assign restart = i_start &&
                   ((st_q == S_DONE) || (st_q == S_ERR));
  assign n_inc   = n_q + NW'(1);

  subservient_byte_packer u_pack (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (restart),
    .i_en   (take),
    .i_byte (i_byte_data),
    .o_word (word),
    .o_last (last)
  );

  always_comb begin
    st_d  = st_q;
    n_d   = n_q;
    len_d = len_q;
    to_d  = to_q;
    adr_d = adr_q;
    dat_d = dat_q;
    unique case (1'b1)
      st_q == S_LEN: begin
        if (last) begin
          if (word == '0) begin
            st_d = S_DONE;
          end else if (word > 32'(MAX_WORDS)) begin
            st_d = S_ERR;
          end else begin
            len_d = word[NW-1:0];
            st_d  = S_DATA;
          end
        end
      end
      st_q == S_DATA: begin
        if (last) begin
          dat_d = word;
          adr_d = BASE_ADR + (32'(n_q) << 2);
          to_d  = '0;
          st_d  = S_WRITE;
        end
      end
      st_q == S_WRITE: begin
        if (i_wb_dbg_ack) begin
          n_d  = n_inc;
          st_d = (n_inc == len_q) ? S_DONE : S_DATA;
        end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          st_d = S_ERR;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      (st_q == S_DONE) || (st_q == S_ERR): begin
        if (i_start) begin
          n_d   = '0;
          len_d = '0;
          st_d  = S_LEN;
        end
      end
      default: st_d = S_LEN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q  <= S_LEN;
      arm_q <= 1'b0;
      n_q   <= '0;
      len_q <= '0;
      to_q  <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      st_q  <= st_d;
      arm_q <= 1'b1;
      n_q   <= n_d;
      len_q <= len_d;
      to_q  <= to_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign o_wb_dbg_stb = (st_q == S_WRITE);
  assign o_wb_dbg_we  = o_wb_dbg_stb;
  assign o_wb_dbg_sel = o_wb_dbg_stb ? SEL_ALL : 4'h0;
  assign o_wb_dbg_adr = adr_q;
  assign o_wb_dbg_dat = dat_q;
  assign o_debug_mode = (st_q != S_DONE);
  assign o_done       = (st_q == S_DONE);
  assign o_error      = (st_q == S_ERR);

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Directed bench for the debug-port loader.
// Small MAX_WORDS/ACK_TIMEOUT keep boundary cases short.
module tb_subservient_dbg_loader;

  localparam int MW = 4;
  localparam int AT = 8;

  logic        i_clk, i_rst_n, i_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready, o_debug_mode;
  logic [31:0] o_wb_dbg_adr, o_wb_dbg_dat;
  logic [3:0]  o_wb_dbg_sel;
  logic        o_wb_dbg_we, o_wb_dbg_stb;
  logic        i_wb_dbg_ack;
  logic [31:0] i_wb_dbg_rdt;
  logic        o_done, o_error;

  int checks = 0;
  int errors = 0;

  bit ack_en = 1;
  int ack_dly = 0;
  bit rnd_gap = 0;
  int acnt = 0;
  int stb_cyc = 0;
  logic [31:0] wadr[$];
  logic [31:0] wdat[$];
  logic        pstb = 0;
  logic [31:0] padr, pdat;

  subservient_dbg_loader #(
    .BASE_ADR   (32'h0),
    .MAX_WORDS  (MW),
    .ACK_TIMEOUT(AT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_byte_valid(i_byte_valid),
    .i_byte_data (i_byte_data),
    .o_byte_ready(o_byte_ready),
    .o_debug_mode(o_debug_mode),
    .o_wb_dbg_adr(o_wb_dbg_adr),
    .o_wb_dbg_dat(o_wb_dbg_dat),
    .o_wb_dbg_sel(o_wb_dbg_sel),
    .o_wb_dbg_we (o_wb_dbg_we),
    .o_wb_dbg_stb(o_wb_dbg_stb),
    .i_wb_dbg_ack(i_wb_dbg_ack),
    .i_wb_dbg_rdt(i_wb_dbg_rdt),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: acks after ack_dly stb cycles, logs
  // writes, and watches bus stability and ready in WRITE.
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      if (o_wb_dbg_stb) begin
        stb_cyc++;
        chk("rdy_in_write", o_byte_ready, 0);
        if (pstb) begin
          chk("adr_stable", o_wb_dbg_adr, padr);
          chk("dat_stable", o_wb_dbg_dat, pdat);
        end
      end
      pstb = o_wb_dbg_stb;
      padr = o_wb_dbg_adr;
      pdat = o_wb_dbg_dat;
      if (i_wb_dbg_ack) begin
        i_wb_dbg_ack = 0;
        acnt = 0;
      end else if (o_wb_dbg_stb && ack_en) begin
        if (acnt == ack_dly) begin
          wadr.push_back(o_wb_dbg_adr);
          wdat.push_back(o_wb_dbg_dat);
          chk("sel", o_wb_dbg_sel, 4'hF);
          chk("we", o_wb_dbg_we, 1);
          i_wb_dbg_ack = 1;
          acnt = 0;
        end else begin
          acnt++;
        end
      end else begin
        acnt = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    if (rnd_gap) begin
      i_byte_valid = 0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk);
        #1;
      end
    end
    i_byte_data  = b;
    i_byte_valid = 1;
    k = 0;
    while (!o_byte_ready && k < 200) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    if (k >= 200) chk("byte_wait", k, 0);
    @(posedge i_clk);
    #1;
    i_byte_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(o_done || o_error) && k < 300) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    chk("end_timeout", (k < 300), 1);
  endtask

  task automatic pulse_start();
    i_start = 1;
    @(posedge i_clk);
    #1;
    i_start = 0;
  endtask

  initial begin
    i_rst_n = 0;
    i_start = 0;
    i_byte_valid = 0;
    i_byte_data = 0;
    i_wb_dbg_ack = 0;
    i_wb_dbg_rdt = 32'hDEAD_BEEF;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_dbg", o_debug_mode, 1);
    chk("rst_stb", o_wb_dbg_stb, 0);
    chk("rst_we", o_wb_dbg_we, 0);
    chk("rst_sel", o_wb_dbg_sel, 0);
    chk("rst_adr", o_wb_dbg_adr, 0);
    chk("rst_dat", o_wb_dbg_dat, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_error, 0);
    chk("rst_rdy", o_byte_ready, 0);
    #2;
    i_rst_n = 1;
    #1;
    chk("rel_rdy_low", o_byte_ready, 0);
    @(posedge i_clk);
    #1;
    chk("rel_rdy_high", o_byte_ready, 1);

    // Two-word image, ack one cycle after stb.
    send_word(32'd2);
    send_word(32'h4433_2211);
    chk("lat_stb", o_wb_dbg_stb, 1);
    send_word(32'h8877_6655);
    wait_end();
    chk("img_n", wadr.size(), 2);
    if (wadr.size() == 2) begin
      chk("w0_adr", wadr[0], 32'h0);
      chk("w0_dat", wdat[0], 32'h4433_2211);
      chk("w1_adr", wadr[1], 32'h4);
      chk("w1_dat", wdat[1], 32'h8877_6655);
    end
    chk("img_done", o_done, 1);
    chk("img_dbg", o_debug_mode, 0);
    chk("img_rdy", o_byte_ready, 0);

    // Zero length: DONE right after the 4th byte.
    pulse_start();
    chk("st_dbg", o_debug_mode, 1);
    chk("st_done", o_done, 0);
    chk("st_rdy", o_byte_ready, 1);
    stb_cyc = 0;
    send_word(32'd0);
    chk("len0_done", o_done, 1);
    repeat (3) @(posedge i_clk);
    #1;
    chk("len0_nostb", stb_cyc, 0);

    // Length MAX_WORDS+1 is rejected.
    pulse_start();
    stb_cyc = 0;
    send_word(32'(MW + 1));
    chk("big_err", o_error, 1);
    chk("big_dbg", o_debug_mode, 1);
    chk("big_done", o_done, 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("big_nostb", stb_cyc, 0);
    chk("big_rdy", o_byte_ready, 0);

    // Ack withheld: timeout after exactly AT stb cycles.
    pulse_start();
    ack_en = 0;
    stb_cyc = 0;
    send_word(32'd1);
    send_word(32'hEFBE_ADDE);
    chk("to_dat", o_wb_dbg_dat, 32'hEFBE_ADDE);
    wait_end();
    chk("to_err", o_error, 1);
    @(posedge i_clk);
    #3;
    chk("to_cycles", stb_cyc, AT);
    chk("to_stb", o_wb_dbg_stb, 0);
    ack_en = 1;
    wadr.delete();
    wdat.delete();
    pulse_start();
    chk("to_restart", o_byte_ready, 1);
    send_word(32'd1);
    send_word(32'hF00F_5AA5);
    wait_end();
    chk("rs_done", o_done, 1);
    chk("rs_n", wadr.size(), 1);
    if (wadr.size() == 1) begin
      chk("rs_adr", wadr[0], 32'h0);
      chk("rs_dat", wdat[0], 32'hF00F_5AA5);
    end

    // Slow ack with random valid gaps.
    wadr.delete();
    wdat.delete();
    ack_dly = 5;
    rnd_gap = 1;
    pulse_start();
    send_word(32'd3);
    send_word(32'h0302_0100);
    send_word(32'h1312_1110);
    send_word(32'h2322_2120);
    wait_end();
    rnd_gap = 0;
    chk("sl_done", o_done, 1);
    chk("sl_n", wadr.size(), 3);
    if (wadr.size() == 3) begin
      chk("sl_adr0", wadr[0], 32'h0);
      chk("sl_dat0", wdat[0], 32'h0302_0100);
      chk("sl_adr1", wadr[1], 32'h4);
      chk("sl_dat1", wdat[1], 32'h1312_1110);
      chk("sl_adr2", wadr[2], 32'h8);
      chk("sl_dat2", wdat[2], 32'h2322_2120);
    end

    // Reset pulse during the write of word 1.
    wadr.delete();
    wdat.delete();
    pulse_start();
    send_word(32'd2);
    send_word(32'h0403_0201);
    send_word(32'h0807_0605);
    chk("mr_stb_pre", o_wb_dbg_stb, 1);
    chk("mr_adr_pre", o_wb_dbg_adr, 32'h4);
    @(posedge i_clk);
    #2;
    i_rst_n = 0;
    #1;
    chk("mr_stb_async", o_wb_dbg_stb, 0);
    chk("mr_dbg", o_debug_mode, 1);
    chk("mr_err", o_error, 0);
    #2;
    i_rst_n = 1;
    @(posedge i_clk);
    #1;
    ack_dly = 0;
    wadr.delete();
    wdat.delete();
    send_word(32'd1);
    send_word(32'h00EE_FFC0);
    wait_end();
    chk("mr_done", o_done, 1);
    chk("mr_n", wadr.size(), 1);
    if (wadr.size() == 1) begin
      chk("mr_adr", wadr[0], 32'h0);
      chk("mr_dat", wdat[0], 32'h00EE_FFC0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
